// File: rtl/pixel_writeback.sv
// Pixel write-back buffer: queues accepted pixels from the ray marcher in a small
// FIFO, drains them into frame memory in order, and counts completed frames.
module pixel_writeback #(
  parameter int DEPTH        = 8,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_wea,
  input  logic [19:0] in_addr,
  input  logic [5:0]  in_rgb,
  output logic        in_ready,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [5:0]  mem_data,
  input  logic        mem_ready,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        overflow,
  output logic        addr_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [20:0]   ADDR_LIMIT = 21'(FRAME_PIXELS);
  localparam logic [18:0]   LAST_PIXEL = 19'(FRAME_PIXELS - 1);

  // Handshake: upstream is never stalled. A pixel is taken on any edge with
  // in_wea=1, an in-range address and room in the FIFO; otherwise it is dropped
  // and flagged. Memory side: a write completes on an edge where mem_we and
  // mem_ready are both high; head data holds while mem_ready is low.

  logic [25:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occupancy;
  logic [18:0]   pixel_count;

  logic addr_ok;
  logic is_full;
  logic is_empty;
  logic push;
  logic pop;

  assign addr_ok  = {1'b0, in_addr} < ADDR_LIMIT;
  assign is_full  = (occupancy == FULL_COUNT);
  assign is_empty = (occupancy == '0);
  assign push     = in_wea & addr_ok & ~is_full;
  assign pop      = ~is_empty & mem_ready;

  // Outputs depend on registered state only.
  assign in_ready             = ~is_full;
  assign mem_we               = ~is_empty;
  assign {mem_addr, mem_data} = fifo_mem[rd_ptr];

  // Storage needs no reset: contents are only visible once occupancy says so.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_addr, in_rgb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Frame boundaries follow completed memory writes, not accepted inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_count <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        if (pixel_count == LAST_PIXEL) begin
          pixel_count <= '0;
          frame_count <= frame_count + 16'd1;
          frame_done  <= 1'b1;
        end else begin
          pixel_count <= pixel_count + 19'd1;
        end
      end
    end
  end

  // An out-of-range address wins over a full FIFO when classifying a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      addr_err <= 1'b0;
    end else if (in_wea) begin
      if (!addr_ok) begin
        addr_err <= 1'b1;
      end else if (is_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_writeback.sv
// Bench for pixel_writeback: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_pixel_writeback;

  localparam int TB_DEPTH = 8;
  localparam int TB_FRAME = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wea = 1'b0;
  logic [19:0] addr = '0;
  logic [5:0]  rgb = '0;
  logic        mready = 1'b0;

  logic        in_ready, mem_we, frame_done, overflow, addr_err;
  logic [19:0] mem_addr;
  logic [5:0]  mem_data;
  logic [15:0] frame_count;

  logic        b_in_ready, b_mem_we, b_frame_done, b_overflow, b_addr_err;
  logic [19:0] b_mem_addr;
  logic [5:0]  b_mem_data;
  logic [15:0] b_frame_count;

  pixel_writeback #(.DEPTH(TB_DEPTH), .FRAME_PIXELS(TB_FRAME)) dut (
    .clk(clk), .rst(rst), .in_wea(wea), .in_addr(addr), .in_rgb(rgb),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mready), .frame_done(frame_done), .frame_count(frame_count),
    .overflow(overflow), .addr_err(addr_err)
  );

  pixel_writeback dut_big (
    .clk(clk), .rst(rst), .in_wea(wea), .in_addr(addr), .in_rgb(rgb),
    .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .mem_ready(mready), .frame_done(b_frame_done), .frame_count(b_frame_count),
    .overflow(b_overflow), .addr_err(b_addr_err)
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted {addr,rgb} pixels plus frame bookkeeping.
  logic [25:0] exp_q[$];
  int          m_pix;
  logic [15:0] m_fc;
  logic        m_fd, m_ov, m_ae;
  bit          m_pop, m_full, m_push;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pix = 0;
      m_fc  = '0;
      m_fd  = 1'b0;
      m_ov  = 1'b0;
      m_ae  = 1'b0;
    end else begin
      m_pop  = (exp_q.size() != 0) && (mready === 1'b1);
      m_full = (exp_q.size() == TB_DEPTH);
      m_push = 1'b0;
      m_fd   = 1'b0;
      if (wea) begin
        if (int'(addr) >= TB_FRAME) m_ae = 1'b1;
        else if (m_full)            m_ov = 1'b1;
        else                        m_push = 1'b1;
      end
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_pix++;
        if (m_pix == TB_FRAME) begin
          m_pix = 0;
          m_fc  = m_fc + 16'd1;
          m_fd  = 1'b1;
        end
      end
      if (m_push) exp_q.push_back({addr, rgb});
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mem_we", mem_we, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("mem_addr", mem_addr, exp_q[0][25:6]);
        check("mem_data", mem_data, exp_q[0][5:0]);
      end
      check("in_ready", in_ready, exp_q.size() != TB_DEPTH);
      check("overflow", overflow, m_ov);
      check("addr_err", addr_err, m_ae);
      check("frame_done", frame_done, m_fd);
      check("frame_count", frame_count, m_fc);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [19:0] a, input logic [5:0] c, input logic r);
    wea = w;
    addr = a;
    rgb = c;
    mready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    check("rst_mem_we", mem_we, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_overflow", overflow, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_frame_count", frame_count, 0);

    // Single pixel, on the full-frame instance.
    drive(1'b1, 20'h00010, 6'b101101, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("single_we", b_mem_we, 1);
    check("single_addr", b_mem_addr, 20'h00010);
    check("single_data", b_mem_data, 6'b101101);
    tick();
    check("single_we_off", b_mem_we, 0);

    // Backpressure: fill, overflow, then ordered drain.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 20'(i), 6'(i), 1'b0);
      tick();
      if (i == 6) check("bp_ready_7", in_ready, 1);
      if (i == 7) check("bp_ready_8", in_ready, 0);
    end
    check("bp_overflow", overflow, 1);
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("bp_drain_we", mem_we, 1);
      check("bp_drain_addr", mem_addr, 32'(i));
      tick();
    end
    check("bp_drained", mem_we, 0);

    // Full FIFO with a simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 20'(i), 6'(i), 1'b0);
      tick();
    end
    drive(1'b1, 20'd9, 6'd9, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("fullpop_overflow", overflow, 1);
    check("fullpop_ready", in_ready, 1);
    check("fullpop_head", mem_addr, 1);
    repeat (6) tick();
    check("fullpop_last", mem_addr, 7);
    tick();
    check("fullpop_empty", mem_we, 0);

    // Address range on the full-frame instance.
    do_reset();
    drive(1'b1, 20'd307200, 6'h11, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("range_no_we", b_mem_we, 0);
    check("range_addr_err", b_addr_err, 1);
    check("range_overflow", b_overflow, 0);
    drive(1'b1, 20'd307199, 6'h2a, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("range_last_we", b_mem_we, 1);
    check("range_last_addr", b_mem_addr, 307199);
    check("range_last_data", b_mem_data, 6'h2a);

    // Frame completion with a 16-pixel frame.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 20'(i), 6'(i), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    check("frame_pre_done", frame_done, 0);
    check("frame_last_addr", mem_addr, 15);
    tick();
    check("frame_done", frame_done, 1);
    check("frame_count_1", frame_count, 1);
    check("model_fc_1", m_fc, 16'd1);
    tick();
    check("frame_done_off", frame_done, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 20'(i), 6'(i), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) tick();
    check("frame_count_2", frame_count, 2);
    check("model_fc_2", m_fc, 16'd2);

    // Reset in the middle of a queued burst.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 20'(i + 8), 6'(i), 1'b0);
      tick();
    end
    wea = 1'b1;
    addr = 20'd20;
    tick();
    do_reset();
    check("midrst_we", mem_we, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_overflow", overflow, 0);
    check("midrst_addr_err", addr_err, 0);
    drive(1'b1, 20'd3, 6'h15, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("midrst_new_we", mem_we, 1);
    check("midrst_new_addr", mem_addr, 3);
    check("midrst_new_data", mem_data, 6'h15);
    tick();
    check("midrst_after", mem_we, 0);

    // Randomized traffic, scored by the model every cycle.
    do_reset();
    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 7, 20'($urandom_range(0, 19)),
            6'($urandom_range(0, 63)), $urandom_range(0, 1) == 1);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    repeat (10) tick();
    check("rand_drained", mem_we, 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
